// File: rtl/dal_sched.sv
// BDAL datapath owner arbiter: grants the transceivers to the register slave, the vector
// responder or the DMA master, with settle delay before drive and a turnaround cycle between owners.
module dal_sched #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk20,
  input  logic       reset_L,
  input  logic       sINIT,
  input  logic       sRDIN,
  input  logic       sRDOUT,
  input  logic       slv_match,
  input  logic       vec_req,
  input  logic       dma_req,
  input  logic       dma_drive,
  input  logic       dma_DALst,
  input  logic       dma_DALbe,
  output logic       dma_gnt,
  output logic       slv_wr_stb,
  output logic [1:0] sel,
  output logic       DALtx,
  output logic       DALst,
  output logic       DALbe_L,
  output logic       TRPLY,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle, StSlvSettle, StSlvDrive, StSlvWr, StVecSettle, StVecDrive, StDma, StRelease
  } state_e;

  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] sel_q, sel_d;
  logic       daltx_q, daltx_d;
  logic       drive_q, drive_d;
  logic       trply_q, trply_d;
  logic       stb_q, stb_d;
  logic       gnt_q, gnt_d;
  logic       busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (sINIT) begin
      // Abort always passes through one dead cycle; idle (and the dead cycle) park in idle.
      state_d = (state_q == StIdle || state_q == StRelease) ? StIdle : StRelease;
      cnt_d   = 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (slv_match && sRDIN) begin
            state_d = StSlvSettle;
            cnt_d   = SettleLast;
          end else if (slv_match && sRDOUT) begin
            state_d = StSlvWr;
          end else if (vec_req) begin
            state_d = StVecSettle;
            cnt_d   = SettleLast;
          end else if (dma_req) begin
            state_d = StDma;
          end
        end
        StSlvSettle: begin
          if (cnt_q == 4'd0) state_d = StSlvDrive;
          else               cnt_d   = cnt_q - 4'd1;
        end
        StSlvDrive: if (!sRDIN || !slv_match) state_d = StRelease;
        StSlvWr:    if (!sRDOUT || !slv_match) state_d = StRelease;
        StVecSettle: begin
          if (cnt_q == 4'd0) state_d = StVecDrive;
          else               cnt_d   = cnt_q - 4'd1;
        end
        StVecDrive: if (!vec_req) state_d = StRelease;
        StDma:      if (!dma_req) state_d = StRelease;
        StRelease:  state_d = StIdle;
        default:    state_d = StIdle;
      endcase
    end
  end

  // Output registers are loaded from the next state so pins change on the transition edge.
  always_comb begin
    sel_d   = 2'd0;
    daltx_d = 1'b0;
    drive_d = 1'b0;
    trply_d = 1'b0;
    stb_d   = 1'b0;
    gnt_d   = 1'b0;
    busy_d  = (state_d != StIdle);
    unique case (state_d)
      StSlvSettle: begin
        sel_d   = 2'd1;
        daltx_d = 1'b1;
      end
      StSlvDrive: begin
        sel_d   = 2'd1;
        daltx_d = 1'b1;
        drive_d = 1'b1;
        trply_d = 1'b1;
      end
      StSlvWr: begin
        trply_d = 1'b1;
        stb_d   = (state_q == StIdle);
      end
      StVecSettle: begin
        sel_d   = 2'd2;
        daltx_d = 1'b1;
      end
      StVecDrive: begin
        sel_d   = 2'd2;
        daltx_d = 1'b1;
        drive_d = 1'b1;
        trply_d = 1'b1;
      end
      StDma: begin
        sel_d = 2'd3;
        gnt_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk20 or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      sel_q   <= 2'd0;
      daltx_q <= 1'b0;
      drive_q <= 1'b0;
      trply_q <= 1'b0;
      stb_q   <= 1'b0;
      gnt_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      daltx_q <= daltx_d;
      drive_q <= drive_d;
      trply_q <= trply_d;
      stb_q   <= stb_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  // DMA master controls the transceiver pins directly, but only behind the registered grant.
  assign DALtx      = gnt_q ? dma_drive  : daltx_q;
  assign DALst      = gnt_q ? dma_DALst  : drive_q;
  assign DALbe_L    = gnt_q ? ~dma_DALbe : ~drive_q;
  assign TRPLY      = trply_q;
  assign sel        = sel_q;
  assign slv_wr_stb = stb_q;
  assign dma_gnt    = gnt_q;
  assign busy       = busy_q;

endmodule
